// File: rtl/ad7928_pkg.sv
// Shared definitions for the AD7928 serial-interface emulator: control-word
// layout, frame geometry, FSM states and the output-coding helper.
package ad7928_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADC_BITS   = 12;
  localparam int NUM_CH     = 8;

  localparam int WRITE_BIT  = 15;
  localparam int ADD_HI     = 12;
  localparam int ADD_LO     = 10;
  localparam int CODING_BIT = 4;

  // Full control-word layout; SEQ, PM, SHADOW and RANGE are stored only.
  typedef struct packed {
    logic       write;
    logic       seq;
    logic       dontc13;
    logic [2:0] add;
    logic [1:0] pm;
    logic       shadow;
    logic       dontc6;
    logic       range;
    logic       coding;
    logic [3:0] dontc3_0;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Straight binary passes through; two's complement flips the MSB.
  function automatic logic [ADC_BITS-1:0] code_sample(input logic [ADC_BITS-1:0] s,
                                                       input logic coding);
    return coding ? s : {~s[ADC_BITS-1], s[ADC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/ad7928_slave_emu_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a history
// flop that turns level changes into single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_hist <= w_level;
    end
  end

  assign o_rise = ~r_hist &  w_level;
  assign o_fall =  r_hist & ~w_level;

endmodule

// File: rtl/ad7928_slave_emu.sv
// SPI responder emulating the AD7928: snapshots a channel on CS_n fall,
// shifts it out MSB first on SCLK falls and captures the control word.
module ad7928_slave_emu
  import ad7928_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_sclk,
  input  logic        adc_cs_n,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic [95:0] ch_data,
  output logic [2:0]  cur_addr,
  output logic [15:0] ctrl_word,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  state_t                r_state;
  state_t                w_state_next;
  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_ctrl;
  logic [3:0]            r_cnt;
  logic [2:0]            r_addr;
  logic                  r_dout;
  logic                  r_done;
  logic [SYNC_STAGES-1:0] r_din_sync;

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic w_din_s, w_unused;
  logic w_load, w_shift, w_last, w_abort;
  logic [ADC_BITS-1:0]   w_sample;
  logic [FRAME_BITS-1:0] w_snap;
  logic [FRAME_BITS-1:0] w_rx_next;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (adc_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (adc_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // DIN is only ever sampled on a detected SCLK fall, so no edge logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_din_sync <= '0;
    else     r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
  end

  assign w_din_s   = r_din_sync[SYNC_STAGES-1];
  assign w_unused  = w_sclk_rise;
  assign w_sample  = ch_data[int'(r_addr)*ADC_BITS +: ADC_BITS];
  assign w_snap    = {1'b0, r_addr, code_sample(w_sample, r_ctrl[CODING_BIT])};
  assign w_rx_next = {r_rx[FRAME_BITS-2:0], w_din_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // CS_n fall outranks everything, including a coincident SCLK fall.
  always_comb begin
    w_state_next = r_state;
    if (w_cs_fall) begin
      w_state_next = ST_SHIFT;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_cs_rise)                                       w_state_next = ST_IDLE;
          else if (w_sclk_fall && r_cnt == 4'(FRAME_BITS - 1)) w_state_next = ST_HOLD;
        end
        ST_HOLD:  if (w_cs_rise) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load  = w_cs_fall;
    w_abort = 1'b0;
    w_shift = 1'b0;
    w_last  = 1'b0;
    if (!w_cs_fall && r_state == ST_SHIFT) begin
      w_abort = w_cs_rise;
      w_shift = w_sclk_fall && !w_cs_rise;
      w_last  = w_shift && (r_cnt == 4'(FRAME_BITS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_done <= 1'b0;
      r_ctrl <= '0;
      r_addr <= '0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_tx   <= w_snap;
        r_rx   <= '0;
        r_cnt  <= '0;
        r_dout <= w_snap[FRAME_BITS-1];
      end else if (w_shift) begin
        r_rx  <= w_rx_next;
        r_cnt <= r_cnt + 4'd1;
        r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
        if (w_last) begin
          r_dout <= 1'b0;
          if (w_rx_next[WRITE_BIT]) begin
            r_ctrl <= w_rx_next;
            r_addr <= w_rx_next[ADD_HI:ADD_LO];
          end
        end else begin
          r_dout <= r_tx[FRAME_BITS-2];
        end
      end else if (w_abort) begin
        r_dout <= 1'b0;
      end
    end
  end

  assign adc_dout   = r_dout;
  assign cur_addr   = r_addr;
  assign ctrl_word  = r_ctrl;
  assign frame_done = r_done;
  assign dbg_state  = r_state;

endmodule
